// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: width helpers and the debug status bundle shared by sync_fifo_param
// and its storage sub-module.
package sync_fifo_pkg;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: FIFO storage array with one synchronous write port and one registered
// read port; the read register clears on the synchronous active-low reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_wrEn,
    input  logic [ptr_width(FIFO_DEPTH)-1:0]    i_wrAddr,
    input  logic [DATA_WIDTH-1:0]               i_wrData,
    input  logic                                i_rdEn,
    input  logic [ptr_width(FIFO_DEPTH)-1:0]    i_rdAddr,
    output logic [DATA_WIDTH-1:0]               o_rdData
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdData;

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdData <= '0;
        end else if (i_rdEn) begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock circular-buffer FIFO with occupancy count,
// threshold flags and a read-valid strobe. Define SYNC_FIFO_ERR_FLAGS_EN for sticky
// overflow/underflow registers; otherwise those ports are tied low.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH-1:0]               din,
    input  logic                                wr,
    input  logic                                rr,
    output logic [DATA_WIDTH-1:0]               dout,
    output logic                                dout_valid,
    output logic                                empty,
    output logic                                full,
    output logic                                almost_empty,
    output logic                                almost_full,
    output logic [cnt_width(FIFO_DEPTH)-1:0]    count,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int PW = ptr_width(FIFO_DEPTH);
    localparam int CW = cnt_width(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_countNext;
    logic          r_doutValid;
    logic          w_empty;
    logic          w_full;
    logic          w_wrAcc;
    logic          w_rdAcc;
    logic          w_overflow;
    logic          w_underflow;
    fifo_status_t  w_status;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

    // Acceptance uses the registered flags, so a full FIFO rejects a write even when
    // a read drains an entry in the same cycle (and symmetrically when empty).
    assign w_wrAcc = wr && !w_full;
    assign w_rdAcc = rr && !w_empty;

    always_comb begin
        w_countNext = r_count;
        case ({w_wrAcc, w_rdAcc})
            2'b10:   w_countNext = r_count + CW'(1);
            2'b01:   w_countNext = r_count - CW'(1);
            default: w_countNext = r_count;
        endcase
    end

    // Pointers wrap for free because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_doutValid <= 1'b0;
        end else begin
            if (w_wrAcc) begin
                r_wrPtr <= r_wrPtr + PW'(1);
            end
            if (w_rdAcc) begin
                r_rdPtr <= r_rdPtr + PW'(1);
            end
            r_count     <= w_countNext;
            r_doutValid <= w_rdAcc;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .i_wrEn   (w_wrAcc && rst),
        .i_wrAddr (r_wrPtr),
        .i_wrData (din),
        .i_rdEn   (w_rdAcc),
        .i_rdAddr (r_rdPtr),
        .o_rdData (dout)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rr && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign w_overflow  = r_overflow;
    assign w_underflow = r_underflow;
`else
    assign w_overflow  = 1'b0;
    assign w_underflow = 1'b0;
`endif

    assign w_status.empty        = w_empty;
    assign w_status.full         = w_full;
    assign w_status.almost_empty = (r_count <= AE_CNT);
    assign w_status.almost_full  = (r_count >= AF_CNT);
    assign w_status.overflow     = w_overflow;
    assign w_status.underflow    = w_underflow;

    assign empty        = w_status.empty;
    assign full         = w_status.full;
    assign almost_empty = w_status.almost_empty;
    assign almost_full  = w_status.almost_full;
    assign overflow     = w_status.overflow;
    assign underflow    = w_status.underflow;
    assign count        = r_count;
    assign dout_valid   = r_doutValid;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param at its default
// 8x8 configuration (AF_THRESH=6, AE_THRESH=1).
module tb_sync_fifo_param;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       wr;
    logic       rr;
    logic [7:0] dout;
    logic       dout_valid;
    logic       empty;
    logic       full;
    logic       almost_empty;
    logic       almost_full;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int nAsserts = 0;
    int nFails   = 0;

    logic [7:0] expQ[$];
    logic [7:0] expWord;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (8),
        .AF_THRESH  (6),
        .AE_THRESH  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .wr           (wr),
        .rr           (rr),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic applyStimulus(input logic w, input logic r, input logic [7:0] d);
        wr  = w;
        rr  = r;
        din = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rr = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        wr  = 1'b0;
        rr  = 1'b0;
        din = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        checkOutput("reset count", 32'(count), 0);
        checkOutput("reset empty", 32'(empty), 1);
        checkOutput("reset full", 32'(full), 0);
        checkOutput("reset almost_empty", 32'(almost_empty), 1);
        checkOutput("reset almost_full", 32'(almost_full), 0);
        checkOutput("reset dout", 32'(dout), 0);
        checkOutput("reset dout_valid", 32'(dout_valid), 0);
        checkOutput("reset overflow", 32'(overflow), 0);
        checkOutput("reset underflow", 32'(underflow), 0);

        // Fill with 0x11..0x88 and watch the threshold flags move.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h11 * (i + 1)));
            checkOutput("fill count", 32'(count), 32'(i + 1));
            checkOutput("fill almost_full", 32'(almost_full), 32'((i + 1) >= 6));
            checkOutput("fill almost_empty", 32'(almost_empty), 32'((i + 1) <= 1));
            checkOutput("fill full", 32'(full), 32'((i + 1) == 8));
            checkOutput("fill empty", 32'(empty), 0);
        end

        applyStimulus(1'b1, 1'b0, 8'hFF);
        checkOutput("overfill count", 32'(count), 8);
        checkOutput("overfill full", 32'(full), 1);
        checkOutput("overfill overflow", 32'(overflow), 32'(ERR_EN));

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("drain dout", 32'(dout), 32'(8'(8'h11 * (i + 1))));
            checkOutput("drain dout_valid", 32'(dout_valid), 1);
            checkOutput("drain count", 32'(count), 32'(7 - i));
            checkOutput("drain full", 32'(full), 0);
        end
        checkOutput("drained empty", 32'(empty), 1);
        checkOutput("overflow sticky", 32'(overflow), 32'(ERR_EN));

        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("idle dout hold", 32'(dout), 32'h88);
        checkOutput("idle dout_valid", 32'(dout_valid), 0);

        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("underrun dout_valid", 32'(dout_valid), 0);
        checkOutput("underrun count", 32'(count), 0);
        checkOutput("underrun dout hold", 32'(dout), 32'h88);
        checkOutput("underrun underflow", 32'(underflow), 32'(ERR_EN));

        // Hold four entries, then stream through the pointer wrap.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'hA0 + i));
            expQ.push_back(8'(8'hA0 + i));
        end
        checkOutput("prestream count", 32'(count), 4);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 1'b1, 8'(8'hB0 + k));
            expWord = expQ.pop_front();
            expQ.push_back(8'(8'hB0 + k));
            checkOutput("stream dout", 32'(dout), 32'(expWord));
            checkOutput("stream dout_valid", 32'(dout_valid), 1);
            checkOutput("stream count", 32'(count), 4);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 8'h00);
            checkOutput("poststream dout", 32'(dout), 32'(8'hC0 + i));
        end
        checkOutput("poststream empty", 32'(empty), 1);

        // Simultaneous request on an empty FIFO: no bypass.
        applyStimulus(1'b1, 1'b1, 8'h5A);
        checkOutput("empty rw count", 32'(count), 1);
        checkOutput("empty rw dout_valid", 32'(dout_valid), 0);
        checkOutput("empty rw dout hold", 32'(dout), 32'hC3);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("empty rw readback", 32'(dout), 32'h5A);
        checkOutput("empty rw readback valid", 32'(dout_valid), 1);
        checkOutput("empty rw final count", 32'(count), 0);

        // Reset with five queued entries and a write in the reset cycle.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(i + 1));
        end
        checkOutput("prereset count", 32'(count), 5);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h77);
        rst = 1'b1;
        checkOutput("midreset count", 32'(count), 0);
        checkOutput("midreset empty", 32'(empty), 1);
        checkOutput("midreset dout", 32'(dout), 0);
        checkOutput("midreset dout_valid", 32'(dout_valid), 0);
        checkOutput("midreset almost_full", 32'(almost_full), 0);
        checkOutput("midreset almost_empty", 32'(almost_empty), 1);
        checkOutput("midreset overflow", 32'(overflow), 0);
        checkOutput("midreset underflow", 32'(underflow), 0);

        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("postreset read valid", 32'(dout_valid), 0);
        checkOutput("postreset count", 32'(count), 0);
        checkOutput("postreset underflow", 32'(underflow), 32'(ERR_EN));

        applyStimulus(1'b1, 1'b0, 8'h33);
        checkOutput("postreset write count", 32'(count), 1);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("postreset readback", 32'(dout), 32'h33);
        checkOutput("postreset readback valid", 32'(dout_valid), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the successor to the fixed 8x8 instruction FIFO. It provides true first-in-first-out ordering through a circular buffer and accepts a simultaneous read and write in one cycle. It also exposes an occupancy count, almost-full and almost-empty thresholds, and a registered read data valid strobe. It sits between the instruction fetch stage and the decode stage, and is reusable for any single-clock buffering.

## Interface
Parameters:
- DATA_WIDTH, 8: bits per entry.
- FIFO_DEPTH, 8: number of entries; power of two, at least 2.
- AF_THRESH, FIFO_DEPTH-2: almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 1: almost_empty asserts when count <= AE_THRESH.

Ports (CW = $clog2(FIFO_DEPTH)+1):
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-low.
- din  in  DATA_WIDTH  write data.
- wr  in  1  write request.
- rr  in  1  read request.
- dout  out  DATA_WIDTH  read data, registered.
- dout_valid  out  1  dout updated this cycle by an accepted read.
- empty  out  1  count == 0.
- full  out  1  count == FIFO_DEPTH.
- almost_empty  out  1  count <= AE_THRESH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  CW  current occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Storage is a circular buffer indexed by wr_ptr and rd_ptr, each $clog2(FIFO_DEPTH) bits wide. Both pointers wrap naturally from FIFO_DEPTH-1 to 0.
- Write accepted: w_acc = wr && !full. On w_acc, mem[wr_ptr] <= din and wr_ptr increments.
- Read accepted: r_acc = rr && !empty. On r_acc, dout <= mem[rd_ptr], rd_ptr increments, and dout_valid is 1 in the next cycle.
- With no accepted read, dout holds its last value and dout_valid is 0.
- Count update: count <= count + w_acc - r_acc. The result is never negative and never exceeds FIFO_DEPTH.
- Flags are decoded from the registered count. Each flag changes on the same edge as count.
- Simultaneous wr and rr:
  - Not empty and not full: both are accepted, and count is unchanged.
  - Full: the read is accepted and the write is rejected, because full is sampled at the start of the cycle.
  - Empty: the write is accepted and the read is rejected. There is no bypass path, so the written word is readable from the following cycle.
- Rejected requests have no effect on pointers, count or memory.
- Reset, when rst=0 at posedge:
  - wr_ptr, rd_ptr and count go to 0.
  - dout goes to 0; dout_valid, overflow and underflow go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0 (0 if AF_THRESH>0).
  - Memory contents are not cleared.
  - Reset mid-operation discards all queued entries, and requests in that cycle are ignored.

## Timing
- Write-to-read latency: a word written at edge N can be read by a request at edge N+1. Its data appears on dout after edge N+1.
- Read latency: 1 cycle from accepted rr to dout and dout_valid.
- Flags and count reflect all requests accepted up to and including the previous edge.
- Throughput: one write and one read per cycle, sustained.

## Configuration
- SYNC_FIFO_ERR_FLAGS_EN defined:
  - overflow sets on wr && full.
  - underflow sets on rr && empty.
  - Both are sticky until reset.
- SYNC_FIFO_ERR_FLAGS_EN undefined:
  - overflow and underflow are tied to 0.
  - No error registers are synthesised.
  - Ports remain present.

## Structure
- Package sync_fifo_pkg holds:
  - the ptr_width(depth) and cnt_width(depth) functions;
  - the typedef fifo_status_t, a struct of empty, full, almost_empty, almost_full, overflow and underflow, used for debug bundling.
- Sub-module sync_fifo_mem holds the storage array, with one synchronous write port and one registered read port, parametrised by DATA_WIDTH and FIFO_DEPTH.
- The top level holds the pointers, count, flags and error logic.

## Test plan
- Reset, then 8 writes (0x11..0x88), then 8 reads -> dout returns 0x11..0x88 in order, each with dout_valid=1. full=1 after the 8th write, empty=1 after the 8th read.
- Fill to 8, then one more write of 0xFF -> write rejected, count stays 8. With the macro, overflow=1. Next reads return 0x11..0x88 with no 0xFF.
- Hold 4 entries, then wr=rr=1 for 20 cycles -> count stays 4, output order is preserved across pointer wrap, and dout_valid=1 every cycle.
- Empty FIFO, then wr=rr=1 with din=0x5A -> read rejected, count=1, dout_valid=0. The next cycle's read returns 0x5A.
- AF_THRESH=6, AE_THRESH=1 -> almost_full rises on the edge count reaches 6. almost_empty falls when count reaches 2.
- Fill to 5, assert rst=0 for one cycle with wr=1 -> count=0, empty=1, dout=0, flags cleared. The next read request is rejected, and underflow=1 with the macro.
